noc_port_arbiter: RTL

- Responder end of the port-control handshake.
- One instance per output port of a router. It collects per-VC packet requests from the route selectors of all five input ports and grants exactly one input port per virtual channel.
- It holds each grant from packet head to packet tail.
- o_grant feeds the requesters' grant bits, and drives the output port's VC merger through the per-input grant vectors.

---
 rtl/noc_port_arbiter_if.sv | 30 +++
 rtl/noc_port_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/noc_port_arbiter_if.sv
// NoC configuration package and the port-control handshake interface between
// the route selectors (master) and one output-port arbiter (slave).
package noc_port_arbiter_pkg;
  typedef struct packed {
    int unsigned virtual_channels;
  } noc_config_t;

  localparam noc_config_t NOC_DEFAULT_CONFIG = '{virtual_channels: 2};
endpackage

interface noc_port_arbiter_if #(
  parameter int unsigned CHANNELS = 2
);
  logic [5*CHANNELS-1:0] request;
  logic [5*CHANNELS-1:0] start_of_packet;
  logic [5*CHANNELS-1:0] end_of_packet;
  logic [CHANNELS-1:0]   vc_available;
  logic [5*CHANNELS-1:0] grant;
  logic [CHANNELS-1:0]   busy;

  modport master (
    output request, start_of_packet, end_of_packet, vc_available,
    input  grant, busy
  );

  modport slave (
    input  request, start_of_packet, end_of_packet, vc_available,
    output grant, busy
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: per-VC round-robin choice among five input ports,
// holding each grant from packet head until the owner's tail is accepted.
module noc_port_arbiter
  import noc_port_arbiter_pkg::*;
#(
  parameter noc_config_t CONFIG          = NOC_DEFAULT_CONFIG,
  parameter logic [4:0]  AVAILABLE_PORTS = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  noc_port_arbiter_if.slave  port_if
);
  localparam int unsigned CHANNELS = CONFIG.virtual_channels;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t     r_state [CHANNELS];
  logic [2:0] r_last  [CHANNELS];
  state_t     w_next_state [CHANNELS];
  logic [2:0] w_next_last  [CHANNELS];
  logic [4:0] w_req [CHANNELS];
  logic [4:0] w_eop [CHANNELS];

  // First requesting port after 'last', wrapping 4 -> 0.
  function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] last);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= 5; k++) begin
      cand = 3'((32'(last) + k) % 5);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      w_req[v] = '0;
      w_eop[v] = '0;
      for (int unsigned p = 0; p < 5; p++) begin
        w_req[v][p] = port_if.request[CHANNELS*p+v] && port_if.start_of_packet[CHANNELS*p+v]
                      && AVAILABLE_PORTS[p];
        w_eop[v][p] = port_if.end_of_packet[CHANNELS*p+v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        r_state[v] <= ST_IDLE;
        r_last[v]  <= 3'd4;
      end
    end else begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        r_state[v] <= w_next_state[v];
        r_last[v]  <= w_next_last[v];
      end
    end
  end

  // While BUSY, r_last doubles as the owner of the VC.
  always_comb begin
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      w_next_state[v] = r_state[v];
      w_next_last[v]  = r_last[v];
      case (r_state[v])
        ST_IDLE: begin
          if ((|w_req[v]) && port_if.vc_available[v]) begin
            w_next_state[v] = ST_BUSY;
            w_next_last[v]  = rr_pick(w_req[v], r_last[v]);
          end
        end
        ST_BUSY: begin
          if (w_eop[v][r_last[v]]) begin
            w_next_state[v] = ST_IDLE;
          end
        end
        default: w_next_state[v] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    port_if.grant = '0;
    port_if.busy  = '0;
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      port_if.busy[v] = (r_state[v] == ST_BUSY);
      for (int unsigned p = 0; p < 5; p++) begin
        port_if.grant[CHANNELS*p+v] = (r_state[v] == ST_BUSY) && (r_last[v] == 3'(p));
      end
    end
  end
endmodule
